// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Registered program-counter sequencer between decode and the fetch address
// port. Each cycle it picks sequential increment, conditional PC-relative
// branch, register jump, stall-hold or halt. It holds the architectural PC,
// the {Z,V,N} flag register and a RUN/HALTED state. It also emits a one-cycle
// registered flush pulse for the fetch/decode register after every redirect.
//
// Optional feature: define PC_SEQ_BR_COUNT_EN to build two 16-bit saturating
// branch statistics counters. When the macro is undefined, both counter
// outputs are tied to zero.
//
// Parameters
//   PC_W        PC / address width in bits. Must be greater than IMM_W.
//   IMM_W       signed branch offset width, counted in instructions
//   ALIGN_SHIFT log2 of the instruction size in bytes
//   INC         sequential increment in bytes (1 << ALIGN_SHIFT)
//   RESET_PC    PC loaded on reset
//
// Ports
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   stall         in   hold PC and suppress every redirect this cycle
//   flag_we       in   per-bit write enables for {Z,V,N}
//   flag_in       in   new {Z,V,N} values from the ALU
//   br_valid      in   conditional branch present in decode
//   cond          in   branch condition code
//   imm           in   signed branch offset (instructions)
//   jr_valid      in   register jump present in decode
//   jr_target     in   register jump target
//   halt          in   halt instruction present in decode
//   pc            out  current fetch PC (registered)
//   pc_plus       out  pc + INC, the link value (combinational)
//   taken         out  redirect accepted this cycle (combinational)
//   flush         out  high for the cycle after a redirect (registered)
//   halted        out  sequencer is in HALTED
//   br_seen       out  branches seen in RUN without stall (optional)
//   br_taken_cnt  out  branches taken (optional)
// ---------------------------------------------------------------------------
module pc_sequencer #(
  parameter int              PC_W        = 16,
  parameter int              IMM_W       = 9,
  parameter int              ALIGN_SHIFT = 1,
  parameter int              INC         = 2,
  parameter logic [PC_W-1:0] RESET_PC    = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic [2:0]        flag_we,
  input  logic [2:0]        flag_in,
  input  logic              br_valid,
  input  logic [2:0]        cond,
  input  logic [IMM_W-1:0]  imm,
  input  logic              jr_valid,
  input  logic [PC_W-1:0]   jr_target,
  input  logic              halt,
  output logic [PC_W-1:0]   pc,
  output logic [PC_W-1:0]   pc_plus,
  output logic              taken,
  output logic              flush,
  output logic              halted,
  output logic [15:0]       br_seen,
  output logic [15:0]       br_taken_cnt
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  // Clears the byte-offset bits of a jump target so fetch stays aligned.
  localparam logic [PC_W-1:0] ALIGN_MASK =
    ~((PC_W'(1) << ALIGN_SHIFT) - PC_W'(1));

  // Flag register bit positions within {Z,V,N}.
  localparam int Z_BIT = 2;
  localparam int V_BIT = 1;
  localparam int N_BIT = 0;

  // Evaluates a branch condition against the registered flags only. A flag
  // written on the same edge is deliberately not forwarded.
  function automatic logic cond_true(input logic [2:0] c,
                                     input logic [2:0] f);
    logic z;
    logic v;
    logic n;
    logic r;
    z = f[Z_BIT];
    v = f[V_BIT];
    n = f[N_BIT];
    unique case (c)
      3'b000:  r = !z;          // NE
      3'b001:  r = z;           // EQ
      3'b010:  r = !z && !n;    // GT
      3'b011:  r = n;           // LT
      3'b100:  r = z || !n;     // GE
      3'b101:  r = z || n;      // LE
      3'b110:  r = v;           // OV
      3'b111:  r = 1'b1;        // always
    endcase
    return r;
  endfunction

  // Sign-extends the instruction-count offset and scales it to bytes.
  // The scaled result wraps modulo 2^PC_W.
  function automatic logic [PC_W-1:0] branch_offset(input logic [IMM_W-1:0] raw);
    logic signed [PC_W-1:0] ext;
    ext = {{(PC_W-IMM_W){raw[IMM_W-1]}}, raw};
    return $unsigned(ext <<< ALIGN_SHIFT);
  endfunction

  state_t            state;
  logic [2:0]        flags;

  logic              running;
  logic              go;
  logic              cond_ok;
  logic              br_hit;
  logic              jr_go;
  logic              br_go;
  logic              halt_go;
  logic [PC_W-1:0]   br_target;
  logic [PC_W-1:0]   jr_tgt;
  logic [PC_W-1:0]   pc_next;

  // ---- decode-side selection (combinational, current cycle) ----
  assign pc_plus   = pc + PC_W'(INC);
  assign br_target = pc_plus + branch_offset(imm);
  assign jr_tgt    = jr_target & ALIGN_MASK;

  assign running = (state == RUN);
  assign go      = running && !stall;
  assign cond_ok = cond_true(cond, flags);
  assign br_hit  = br_valid && cond_ok;

  // Priority: jump over branch over halt over sequential. The jump
  // discards a simultaneous branch. A redirect discards halt, and decode
  // presents the halt again if it is still valid.
  assign jr_go   = go && jr_valid;
  assign br_go   = go && !jr_valid && br_hit;
  assign halt_go = go && !jr_valid && !br_hit && halt;
  assign taken   = jr_go || br_go;
  assign halted  = (state == HALTED);

  always_comb begin
    pc_next = pc;
    if (jr_go) begin
      pc_next = jr_tgt;
    end else if (br_go) begin
      pc_next = br_target;
    end else if (go && !halt_go) begin
      pc_next = pc_plus;
    end
  end

  // ---- architectural state update (registered) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      flags <= 3'b000;
      state <= RUN;
      flush <= 1'b0;
    end else begin
      pc    <= pc_next;
      flush <= taken;
      if (halt_go) begin
        state <= HALTED;
      end
      // The ALU writes flags regardless of stall or halt state.
      for (int i = 0; i < 3; i++) begin
        if (flag_we[i]) begin
          flags[i] <= flag_in[i];
        end
      end
    end
  end

`ifdef PC_SEQ_BR_COUNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  logic [15:0] seen_q;
  logic [15:0] tkn_q;

  // ---- branch statistics (registered) ----
  // A branch counts as seen even when a simultaneous jump discards it. It
  // counts as taken only when it redirects the PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_q <= 16'd0;
      tkn_q  <= 16'd0;
    end else begin
      if (go && br_valid) begin
        seen_q <= sat_inc(seen_q);
      end
      if (br_go) begin
        tkn_q <= sat_inc(tkn_q);
      end
    end
  end

  assign br_seen      = seen_q;
  assign br_taken_cnt = tkn_q;
`else
  assign br_seen      = 16'd0;
  assign br_taken_cnt = 16'd0;
`endif

endmodule
